// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: RX tick generation, config shadowing and frame FIFO
// between the UART receiver and the host register interface.
module uart_rx_ctrl #(
  parameter int DEPTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_EN,
  input  logic [PRESCALE_W-1:0]    PRESCALE,
  input  logic                     PARITY_EN_CFG,
  input  logic [7:0]               RXDATA,
  input  logic                     VALID_RX,
  input  logic                     PARITY_ERROR,
  input  logic                     STOP_ERROR,
  output logic                     RX_tick,
  output logic                     PARITY_EN,
  input  logic                     RD_EN,
  output logic [7:0]               RD_DATA,
  output logic                     RD_PERR,
  output logic                     RD_SERR,
  output logic                     RD_VALID,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERRUN,
  input  logic                     CLR_OVR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {OFF, RUN} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [PRESCALE_W-1:0] sh_pre;
  logic [PRESCALE_W-1:0] tick_cnt;
  logic                  tick_q;
  logic                  vld_q;
  logic                  vld_prev;
  logic                  rx_edge;
  logic                  do_wr;
  logic                  do_rd;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count_q;
  logic [9:0]            mem [DEPTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF: if (RX_EN)  state_d = RUN;
      RUN: if (!RX_EN) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= OFF;
      sh_pre    <= '0;
      PARITY_EN <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == OFF && RX_EN) begin
        sh_pre    <= PRESCALE;
        PARITY_EN <= PARITY_EN_CFG;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || state_q != RUN) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (tick_cnt == sh_pre) begin
      tick_cnt <= '0;
      tick_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  // a tick computed in the last RUN cycle must not leak into OFF
  assign RX_tick = tick_q && (state_q == RUN);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_q    <= 1'b0;
      vld_prev <= 1'b0;
    end else begin
      vld_q    <= VALID_RX;
      vld_prev <= vld_q;
    end
  end

  assign rx_edge = vld_q && !vld_prev && (state_q == RUN);
  assign EMPTY   = (count_q == '0);
  assign FULL    = (count_q == CW'(DEPTH));
  assign do_rd   = RD_EN && !EMPTY;
  assign do_wr   = rx_edge && (!FULL || do_rd);
  assign COUNT   = count_q;

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wptr] <= {STOP_ERROR, PARITY_ERROR, RXDATA};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      RD_DATA  <= 8'h00;
      RD_PERR  <= 1'b0;
      RD_SERR  <= 1'b0;
      RD_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      RD_VALID <= do_rd;
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr <= rptr + 1'b1;
        {RD_SERR, RD_PERR, RD_DATA} <= mem[rptr];
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // a new drop outranks a clear in the same cycle
      if (rx_edge && !do_wr) OVERRUN <= 1'b1;
      else if (CLR_OVR)      OVERRUN <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It owns the receiver's configuration and sequencing: it generates the RX_tick sampling strobe from a programmable prescaler and drives the receiver's parity enable from a shadow register. It buffers each completed frame, with its error flags, in a small FIFO and hands frames to the host through a read handshake. It sits between the receiver top level (whose RXDATA/VALID_RX/PARITY_ERROR/STOP_ERROR it consumes) and the host register interface.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PRESCALE_W, 8, width of the prescale value.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-low.
- RX_EN  in  1  host enable; a level signal.
- PRESCALE  in  PRESCALE_W  tick period minus 1, in CLK cycles.
- PARITY_EN_CFG  in  1  host parity enable request.
- RXDATA  in  8  received byte from the receiver.
- VALID_RX  in  1  frame-complete indication from the receiver.
- PARITY_ERROR  in  1  parity error of the current frame.
- STOP_ERROR  in  1  stop-bit error of the current frame.
- RX_tick  out  1  sampling strobe to the receiver; one-cycle pulse.
- PARITY_EN  out  1  parity enable to the receiver; shadowed.
- RD_EN  in  1  host read request.
- RD_DATA  out  8  byte popped from the FIFO.
- RD_PERR  out  1  parity error flag of the popped entry.
- RD_SERR  out  1  stop error flag of the popped entry.
- RD_VALID  out  1  one-cycle pulse; RD_* outputs are updated.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- COUNT  out  clog2(DEPTH)+1  FIFO occupancy.
- OVERRUN  out  1  sticky flag: a frame was dropped.
- CLR_OVR  in  1  clears OVERRUN.

## Operation
- The FSM has two states, OFF and RUN; reset enters OFF.
- OFF -> RUN when RX_EN=1. On that transition, PRESCALE is loaded into the shadow register SH_PRE and PARITY_EN_CFG into PARITY_EN. Changes to either input while in RUN are ignored.
- RUN -> OFF when RX_EN=0. The tick counter clears, and RX_tick stays 0 while OFF.
- FIFO contents, COUNT and OVERRUN are retained across OFF/RUN transitions.
- A frame in progress is abandoned on RUN -> OFF because the receiver stops getting ticks. This block does not repair it.
- Tick generator, active in RUN only:
  - A PRESCALE_W-bit counter counts up each cycle.
  - When count == SH_PRE, RX_tick=1 for one cycle and the counter returns to 0.
  - SH_PRE=0 gives a tick every cycle; SH_PRE=N gives one tick every N+1 cycles.
- Frame capture:
  - VALID_RX is registered, and the rising edge (VALID_RX=1, previous=0) is detected in RUN only.
  - A VALID_RX held high for several cycles produces exactly one write.
  - The write stores {STOP_ERROR, PARITY_ERROR, RXDATA} as sampled in the edge cycle.
  - Frames with errors are stored, not discarded.
- Full FIFO:
  - A write with no simultaneous read drops the frame and sets OVERRUN.
  - A write in the same cycle as a read is accepted; COUNT is unchanged.
- OVERRUN stays set until CLR_OVR=1. If CLR_OVR and a new overrun occur in the same cycle, set wins.
- Read: RD_EN=1 with EMPTY=0 pops the head entry.
  - RD_DATA, RD_PERR and RD_SERR are registered and hold their value until the next pop.
  - RD_EN with EMPTY=1 is ignored and RD_VALID stays 0.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - COUNT changes by +1 on a write only, by −1 on a read only, and is unchanged on both or neither.
  - EMPTY = (COUNT==0); FULL = (COUNT==DEPTH).

## Timing
- Reset values: state OFF, RX_tick 0, PARITY_EN 0, RD_DATA 0x00, RD_PERR 0, RD_SERR 0, RD_VALID 0, EMPTY 1, FULL 0, COUNT 0, OVERRUN 0. Tick counter, pointers and the edge register are 0.
- Reset has priority over all inputs and clears the FIFO.
- The FSM changes state one cycle after the RX_EN change is sampled.
- The first RX_tick comes SH_PRE+1 cycles after the cycle RUN is entered.
- Write path: an edge detected at cycle t updates COUNT, EMPTY and FULL at t+1. The edge register adds one cycle, so a VALID_RX rise sampled at t−1 is detected at t.
- Read path: RD_EN sampled at t gives RD_DATA and RD_VALID=1 at t+1, and the COUNT update at t+1.
- A write into an empty FIFO can be read by an RD_EN issued in the first cycle EMPTY=0. There is no fall-through: a same-cycle read on an empty FIFO is ignored.
- OVERRUN is set at t+1 after the dropped edge.

## Test plan
- Reset, then RX_EN=1 with PRESCALE=3 → RX_tick pulses every 4 cycles. Changing PRESCALE to 9 mid-RUN has no effect. RX_EN=0 stops the ticks. Re-enable → the period becomes 10.
- Four frames 0xA5, 0x3C, 0xFF, 0x00, with VALID_RX held 3 cycles each → COUNT=4, FULL=1. Four reads return the bytes in order, each with RD_VALID=1, and end with EMPTY=1.
- Fill DEPTH=4, then send a fifth frame 0x77 → it is dropped and OVERRUN=1. Then a frame edge together with RD_EN while full → accepted, COUNT stays 4. CLR_OVR → OVERRUN=0.
- Frame 0x5A with PARITY_ERROR=1, then 0x11 with STOP_ERROR=1 → the reads return RD_PERR=1/RD_SERR=0, then RD_PERR=0/RD_SERR=1.
- RD_EN on an empty FIFO → RD_VALID=0 and RD_DATA keeps its previous value. VALID_RX edge while OFF → no write.
- Assert RST=0 for one cycle mid-stream with COUNT=2 and OVERRUN=1 → all outputs return to their reset values the next cycle.
